// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_sequencer front-end PC controller.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REFILL = 2'd1,
    HALT   = 2'd2
  } pc_seq_state_e;

  localparam int         REFILL_CYCLES = 2;
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return (lsbs & MISALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_seq_stats.sv
// Saturating redirect / stall-cycle counters for pc_sequencer (built only
// when PC_SEQ_STATS_EN is defined).
module pc_seq_stats
  import pc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        redir_inc,
  input  logic        stall_inc,
  output logic [31:0] redir_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redir_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      // Counters stick at all-ones rather than wrapping back to zero.
      if (redir_inc && (redir_cnt != '1)) redir_cnt <= redir_cnt + 32'd1;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register and front-end sequencing for the 5-stage RV32I pipeline.
// Optional statistics counters are enabled with the PC_SEQ_STATS_EN macro.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(9'h100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  input  logic            Halt,
  output logic [PC_W-1:0] PC,
  output logic            IF_ID_En,
  output logic            IF_ID_Flush,
  output logic            ID_EX_Flush,
  output logic            Trap,
  output logic            Halted,
  output logic [31:0]     RedirCnt,
  output logic [31:0]     StallCnt
);

  pc_seq_state_e   state_q, state_d;
  logic [1:0]      refill_cnt_q, refill_cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            trap_q, trap_d;
  logic            halted_q;
  logic            redir_acc, stall_acc;
  logic            brpc_unused;

  // Only the low PC_W bits of the redirect target address the fetch space.
  assign brpc_unused = ^BrPC[31:PC_W];

  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    refill_cnt_d = refill_cnt_q;
    pc_d         = pc_q;
    trap_d       = 1'b0;
    IF_ID_En     = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    redir_acc    = 1'b0;
    stall_acc    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (PcSel) begin
          // Redirect beats halt and stall: the younger instructions are squashed.
          IF_ID_Flush  = 1'b1;
          ID_EX_Flush  = 1'b1;
          redir_acc    = 1'b1;
          state_d      = REFILL;
          refill_cnt_d = 2'(REFILL_CYCLES);
          if (is_misaligned(BrPC[1:0])) begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
          end else begin
            pc_d = BrPC[PC_W-1:0];
          end
        end else if (Halt) begin
          IF_ID_En    = 1'b0;
          ID_EX_Flush = 1'b1;
          state_d     = HALT;
        end else if (Stall) begin
          IF_ID_En    = 1'b0;
          ID_EX_Flush = 1'b1;
          stall_acc   = 1'b1;
        end else begin
          pc_d = pc_q + PC_W'(4);
        end
      end

      REFILL: begin
        // Younger slots are bubbles here, so every request input is ignored.
        pc_d         = pc_q + PC_W'(4);
        refill_cnt_d = refill_cnt_q - 2'd1;
        if (refill_cnt_d == 2'd0) state_d = RUN;
      end

      HALT: begin
        IF_ID_En    = 1'b0;
        ID_EX_Flush = 1'b1;
      end

      default: state_d = RUN;
    endcase

    if (reset) begin
      IF_ID_En    = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // sample the pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      refill_cnt_q <= '0;
      pc_q         <= RESET_PC;
      trap_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      refill_cnt_q <= refill_cnt_d;
      pc_q         <= pc_d;
      trap_q       <= trap_d;
      halted_q     <= (state_d == HALT);
    end
  end

  assign PC     = pc_q;
  assign Trap   = trap_q;
  assign Halted = halted_q;

`ifdef PC_SEQ_STATS_EN
  pc_seq_stats u_stats (
    .clk       (clk),
    .reset     (reset),
    .redir_inc (redir_acc),
    .stall_inc (stall_acc),
    .redir_cnt (RedirCnt),
    .stall_cnt (StallCnt)
  );
`else
  logic stats_unused;
  assign stats_unused = redir_acc ^ stall_acc;
  assign RedirCnt     = '0;
  assign StallCnt     = '0;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Front-end PC controller for the 5-stage RV32I pipeline. Owns the PC register and sequences it from the branch unit's redirect request (`PcSel`/`BrPC`, resolved in EX), the hazard unit's load-use stall and a decode-stage halt request. Generates the IF/ID and ID/EX flush/enable controls and traps on misaligned redirect targets.

## Interface
- `PC_W`, 9: PC width in bits. Byte address; bits [1:0] are always 0.
- `RESET_PC`, 0: PC value after reset, `PC_W` bits.
- `TRAP_VEC`, 9'h100: PC loaded on a misaligned-target trap, `PC_W` bits.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `PcSel` in 1: branch unit redirect request, EX stage.
- `BrPC` in 32: redirect target; only [PC_W-1:0] is used.
- `Stall` in 1: load-use stall from the hazard unit.
- `Halt` in 1: ecall/ebreak decoded in ID.
- `PC` out PC_W: current fetch address (registered).
- `IF_ID_En` out 1: IF/ID register enable.
- `IF_ID_Flush` out 1: IF/ID register flush.
- `ID_EX_Flush` out 1: ID/EX register flush (bubble insert).
- `Trap` out 1: one-cycle pulse, misaligned redirect taken.
- `Halted` out 1: core halted (registered).
- `RedirCnt` out 32: taken-redirect counter.
- `StallCnt` out 32: stall-cycle counter.

## Operation
- FSM states: RUN, REFILL, HALT. Reset state RUN.
- Priority in RUN, highest first: redirect (`PcSel`), halt (`Halt`), stall (`Stall`), sequential (PC+4).
- Redirect, `BrPC[1:0]==0`: PC <= `BrPC[PC_W-1:0]`, and `IF_ID_Flush` and `ID_EX_Flush` are high this cycle. Next state is REFILL with the refill counter set to 2.
- Redirect, `BrPC[1:0]!=0`: PC <= `TRAP_VEC` and both flushes are high. `Trap` goes high the next cycle. Next state is REFILL.
- Halt, no redirect: PC holds, `IF_ID_En`=0, `ID_EX_Flush`=1. Next state is HALT.
- Stall: PC holds, `IF_ID_En`=0, `ID_EX_Flush`=1. State stays RUN.
- Sequential: PC <= PC+4, truncated to `PC_W` bits, so it wraps from max to 0 with no flag.
- REFILL: the counter decrements each cycle. PC advances +4. `PcSel`, `Stall` and `Halt` are ignored, because the younger slots are bubbles. The state returns to RUN after the cycle in which the counter reaches 0.
- HALT: PC frozen, `IF_ID_En`=0, `ID_EX_Flush`=1, `Halted`=1. All inputs are ignored. Only `reset` exits this state.
- Redirect and Halt in the same cycle: the redirect wins, because the halting instruction is younger and gets squashed.
- Redirect and Stall in the same cycle: the redirect wins, and the flushes replace the stall.

## Timing
- Reset values: `PC`=`RESET_PC`, `Trap`=0, `Halted`=0, counters=0, state RUN. The combinational outputs during reset are `IF_ID_En`=1 and both flushes 0.
- Flush and enable outputs are combinational from the inputs and state in the same cycle. There is no pipeline delay.
- PC update latency is 1 edge: a request in cycle t gives the new PC in cycle t+1.
- A redirect costs 2 bubble cycles: the instructions at t+1 and t+2 reach EX only after REFILL.
- `Trap` is high in cycle t+1 only.
- A reset asserted mid-REFILL or mid-HALT returns the block to RUN with PC=`RESET_PC` immediately, because the reset is asynchronous.

## Configuration
- `PC_SEQ_STATS_EN` defined:
  - `RedirCnt` increments on each accepted redirect, including traps.
  - `StallCnt` increments on each RUN-state stall cycle.
  - Both counters are 32-bit, saturate at 32'hFFFF_FFFF, and are cleared by `reset`.
- `PC_SEQ_STATS_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- The shared package `pc_seq_pkg` holds:
  - the `pc_seq_state_e` enum (RUN, REFILL, HALT);
  - `REFILL_CYCLES`=2;
  - the misalignment mask constant.
- The optional sub-module `pc_seq_stats` holds the two saturating counters. It is instantiated only under `PC_SEQ_STATS_EN`.

## Test plan
- Reset then 4 free-running cycles: PC 0 -> 4 -> 8 -> 12 -> 16, flushes 0, `IF_ID_En`=1.
- `PcSel`=1 with `BrPC`=0x40 at PC=0x10:
  - both flushes are high that cycle;
  - PC=0x40 next cycle;
  - `PcSel` and `Stall` pulses are ignored during the next 2 cycles;
  - `RedirCnt`=1 with stats enabled.
- `Stall`=1 for 3 cycles at PC=0x20: PC holds 0x20, `IF_ID_En`=0, `ID_EX_Flush`=1, `StallCnt`=3. PC resumes at 0x24.
- `PcSel`, `Halt` and `Stall` all high with `BrPC`=0x80: PC=0x80, `Halted` stays 0, state REFILL.
- `PcSel` with `BrPC`=0x42: PC=`TRAP_VEC` (0x100) next cycle, `Trap` pulses for 1 cycle.
- `Halt`, then `reset` pulsed asynchronously mid-cycle: `Halted`=1 with PC frozen, then PC=0 and `Halted`=0 immediately on reset.
